// File: rtl/l2_ctrl_regs_p_if.sv
// Bus between the L2 FSM (master) and its control/status register bank (slave).
// Carries flush-walk, credit, forward-stall and generic flag signals.
interface l2_ctrl_regs_p_if #(
  parameter int SET_BITS  = 8,
  parameter int WAY_BITS  = 4,
  parameter int REQS_BITS = 2,
  parameter int N_STALL   = 2,
  parameter int N_FLAGS   = 4
);
  localparam int SLOT_BITS = (N_STALL > 1) ? $clog2(N_STALL) : 1;

  logic                 start_flush;
  logic                 step_flush;
  logic                 abort_flush;
  logic                 ongoing_flush;
  logic [SET_BITS-1:0]  flush_set;
  logic [WAY_BITS-1:0]  flush_way;
  logic                 flush_done;

  logic                 req_alloc;
  logic                 req_free;
  logic [REQS_BITS:0]   reqs_cnt;
  logic                 reqs_none_free;
  logic                 reqs_all_free;
  logic                 err_underflow;
  logic                 err_overflow;
  logic                 clr_err;

  logic                 set_stall;
  logic [REQS_BITS-1:0] set_stall_idx;
  logic                 stall_alloc_fail;
  logic                 wr_en_put_reqs;
  logic [REQS_BITS-1:0] reqs_i;
  logic                 put_reqs_atomic;
  logic [REQS_BITS-1:0] reqs_atomic_i;
  logic                 clr_stall;
  logic [SLOT_BITS-1:0] clr_stall_slot;
  logic                 fwd_stall;
  logic                 fwd_stall_ended;
  logic [SLOT_BITS-1:0] ended_slot;
  logic [N_STALL-1:0]   stall_valid;

  logic [N_FLAGS-1:0]   flag_set;
  logic [N_FLAGS-1:0]   flag_clr;
  logic [N_FLAGS-1:0]   flags;

  modport master (
    output start_flush, step_flush, abort_flush,
    input  ongoing_flush, flush_set, flush_way, flush_done,
    output req_alloc, req_free, clr_err,
    input  reqs_cnt, reqs_none_free, reqs_all_free, err_underflow, err_overflow,
    output set_stall, set_stall_idx, wr_en_put_reqs, reqs_i, put_reqs_atomic,
    output reqs_atomic_i, clr_stall, clr_stall_slot,
    input  stall_alloc_fail, fwd_stall, fwd_stall_ended, ended_slot, stall_valid,
    output flag_set, flag_clr,
    input  flags
  );

  modport slave (
    input  start_flush, step_flush, abort_flush,
    output ongoing_flush, flush_set, flush_way, flush_done,
    input  req_alloc, req_free, clr_err,
    output reqs_cnt, reqs_none_free, reqs_all_free, err_underflow, err_overflow,
    input  set_stall, set_stall_idx, wr_en_put_reqs, reqs_i, put_reqs_atomic,
    input  reqs_atomic_i, clr_stall, clr_stall_slot,
    output stall_alloc_fail, fwd_stall, fwd_stall_ended, ended_slot, stall_valid,
    input  flag_set, flag_clr,
    output flags
  );
endinterface

// File: rtl/l2_ctrl_regs_p.sv
// L2 control/status register bank: flush set/way walker, request-buffer credits,
// forward-stall trackers keyed on a request-buffer index, and generic status flags.
module l2_ctrl_regs_p #(
  parameter int SET_BITS  = 8,
  parameter int WAY_BITS  = 4,
  parameter int N_REQS    = 4,
  parameter int REQS_BITS = 2,
  parameter int N_STALL   = 2,
  parameter int N_FLAGS   = 4
) (
  input logic         clk,
  input logic         rst,
  l2_ctrl_regs_p_if.slave ctrl
);
  localparam int SLOT_BITS = (N_STALL > 1) ? $clog2(N_STALL) : 1;
  localparam logic [SET_BITS-1:0]  SET_MAX  = '1;
  localparam logic [WAY_BITS-1:0]  WAY_MAX  = '1;
  localparam logic [REQS_BITS:0]   CNT_FULL = (REQS_BITS + 1)'(N_REQS);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} flush_state_e;

  flush_state_e         state_q, state_d;
  logic [SET_BITS-1:0]  set_q, set_d;
  logic [WAY_BITS-1:0]  way_q, way_d;

  logic [REQS_BITS:0]   cnt_q, cnt_d;
  logic                 under_q, under_d;
  logic                 over_q, over_d;

  logic [N_STALL-1:0]   valid_q, valid_d;
  logic [N_STALL-1:0]   ended_q, ended_d;
  logic [REQS_BITS-1:0] idx_q [N_STALL];
  logic [N_STALL-1:0]   clr_hit, alloc_hit, match, valid_kept;
  logic                 alloc_fail_q, alloc_fail_d;
  logic                 alloc_found;
  logic [SLOT_BITS-1:0] ended_slot_c;

  logic [N_FLAGS-1:0]   flags_q, flags_d;

  // Flush walk: abort wins over everything, start only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    if (ctrl.abort_flush) begin
      state_d = S_IDLE;
      set_d   = '0;
      way_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctrl.start_flush) begin
            state_d = S_WALK;
            set_d   = '0;
            way_d   = '0;
          end
        end
        S_WALK: begin
          if (ctrl.step_flush) begin
            if (way_q != WAY_MAX) begin
              way_d = way_q + 1'b1;
            end else if (set_q != SET_MAX) begin
              way_d = '0;
              set_d = set_q + 1'b1;
            end else begin
              state_d = S_DONE;
              set_d   = '0;
              way_d   = '0;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Simultaneous alloc and free cancel out and never raise an error.
  always_comb begin
    cnt_d   = cnt_q;
    under_d = under_q;
    over_d  = over_q;
    if (ctrl.req_alloc && !ctrl.req_free) begin
      if (cnt_q == '0) under_d = 1'b1;
      else             cnt_d   = cnt_q - 1'b1;
    end else if (ctrl.req_free && !ctrl.req_alloc) begin
      if (cnt_q == CNT_FULL) over_d = 1'b1;
      else                   cnt_d  = cnt_q + 1'b1;
    end
    if (ctrl.clr_err) begin
      under_d = 1'b0;
      over_d  = 1'b0;
    end
  end

  // Release happens before allocation so a freed slot is reusable in the same cycle.
  always_comb begin
    alloc_hit   = '0;
    alloc_found = 1'b0;
    for (int s = 0; s < N_STALL; s++) begin
      if (ctrl.set_stall && !alloc_found && !valid_kept[s]) begin
        alloc_hit[s] = 1'b1;
        alloc_found  = 1'b1;
      end
    end
    alloc_fail_d = ctrl.set_stall && !alloc_found;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_STALL; gi++) begin : g_slot
      assign clr_hit[gi]    = ctrl.clr_stall && (ctrl.clr_stall_slot == SLOT_BITS'(gi));
      assign valid_kept[gi] = valid_q[gi] & ~clr_hit[gi];
      assign match[gi]      = ctrl.wr_en_put_reqs &&
                              ((idx_q[gi] == ctrl.reqs_i) ||
                               (ctrl.put_reqs_atomic && (idx_q[gi] == ctrl.reqs_atomic_i)));
      assign valid_d[gi]    = valid_kept[gi] | alloc_hit[gi];
      assign ended_d[gi]    = alloc_hit[gi] ? 1'b0 : (valid_kept[gi] & (ended_q[gi] | match[gi]));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          idx_q[gi] <= '0;
        end else if (alloc_hit[gi]) begin
          idx_q[gi] <= ctrl.set_stall_idx;
        end
      end
    end
  endgenerate

  always_comb begin
    ended_slot_c = '0;
    for (int s = N_STALL - 1; s >= 0; s--) begin
      if (ended_q[s]) ended_slot_c = SLOT_BITS'(s);
    end
  end

  assign flags_d = (flags_q | ctrl.flag_set) & ~ctrl.flag_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      set_q        <= '0;
      way_q        <= '0;
      cnt_q        <= CNT_FULL;
      under_q      <= 1'b0;
      over_q       <= 1'b0;
      valid_q      <= '0;
      ended_q      <= '0;
      alloc_fail_q <= 1'b0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      set_q        <= set_d;
      way_q        <= way_d;
      cnt_q        <= cnt_d;
      under_q      <= under_d;
      over_q       <= over_d;
      valid_q      <= valid_d;
      ended_q      <= ended_d;
      alloc_fail_q <= alloc_fail_d;
      flags_q      <= flags_d;
    end
  end

  assign ctrl.ongoing_flush    = (state_q == S_WALK);
  assign ctrl.flush_done       = (state_q == S_DONE);
  assign ctrl.flush_set        = set_q;
  assign ctrl.flush_way        = way_q;
  assign ctrl.reqs_cnt         = cnt_q;
  assign ctrl.reqs_none_free   = (cnt_q == '0);
  assign ctrl.reqs_all_free    = (cnt_q == CNT_FULL);
  assign ctrl.err_underflow    = under_q;
  assign ctrl.err_overflow     = over_q;
  assign ctrl.stall_alloc_fail = alloc_fail_q;
  assign ctrl.fwd_stall        = |valid_q;
  assign ctrl.fwd_stall_ended  = |ended_q;
  assign ctrl.ended_slot       = ended_slot_c;
  assign ctrl.stall_valid      = valid_q;
  assign ctrl.flags            = flags_q;
endmodule

// File: tb/tb_l2_ctrl_regs_p.sv
// Directed bench for l2_ctrl_regs_p with a 4x2 flush walk, 4 credits and 2 stall slots.
module tb_l2_ctrl_regs_p;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  l2_ctrl_regs_p_if #(.SET_BITS(2), .WAY_BITS(1), .REQS_BITS(2), .N_STALL(2), .N_FLAGS(4)) ctrl ();

  l2_ctrl_regs_p #(
    .SET_BITS(2), .WAY_BITS(1), .N_REQS(4), .REQS_BITS(2), .N_STALL(2), .N_FLAGS(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ctrl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ctrl.start_flush     = 1'b0;
    ctrl.step_flush      = 1'b0;
    ctrl.abort_flush     = 1'b0;
    ctrl.req_alloc       = 1'b0;
    ctrl.req_free        = 1'b0;
    ctrl.clr_err         = 1'b0;
    ctrl.set_stall       = 1'b0;
    ctrl.set_stall_idx   = '0;
    ctrl.wr_en_put_reqs  = 1'b0;
    ctrl.reqs_i          = '0;
    ctrl.put_reqs_atomic = 1'b0;
    ctrl.reqs_atomic_i   = '0;
    ctrl.clr_stall       = 1'b0;
    ctrl.clr_stall_slot  = '0;
    ctrl.flag_set        = '0;
    ctrl.flag_clr        = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ongoing"}, 32'(ctrl.ongoing_flush), 0);
    chk({tag, "_set"},     32'(ctrl.flush_set), 0);
    chk({tag, "_way"},     32'(ctrl.flush_way), 0);
    chk({tag, "_done"},    32'(ctrl.flush_done), 0);
    chk({tag, "_cnt"},     32'(ctrl.reqs_cnt), 4);
    chk({tag, "_none"},    32'(ctrl.reqs_none_free), 0);
    chk({tag, "_all"},     32'(ctrl.reqs_all_free), 1);
    chk({tag, "_errs"},    32'({ctrl.err_underflow, ctrl.err_overflow}), 0);
    chk({tag, "_afail"},   32'(ctrl.stall_alloc_fail), 0);
    chk({tag, "_fwd"},     32'({ctrl.fwd_stall, ctrl.fwd_stall_ended}), 0);
    chk({tag, "_eslot"},   32'(ctrl.ended_slot), 0);
    chk({tag, "_valid"},   32'(ctrl.stall_valid), 0);
    chk({tag, "_flags"},   32'(ctrl.flags), 0);
  endtask

  initial begin
    clear_inputs();
    #12;
    chk_reset_state("reset");
    rst = 1'b1;
    tick();

    // Full flush walk over 4 sets x 2 ways
    ctrl.start_flush = 1'b1;
    tick();
    chk("walk_ongoing", 32'(ctrl.ongoing_flush), 1);
    chk("walk_set0", 32'(ctrl.flush_set), 0);
    chk("walk_way0", 32'(ctrl.flush_way), 0);
    ctrl.step_flush  = 1'b1;
    ctrl.start_flush = 1'b1;
    tick();
    chk("walk_start_ignored", 32'({ctrl.flush_set, ctrl.flush_way}), 1);
    for (int i = 2; i <= 8; i++) begin
      ctrl.step_flush = 1'b1;
      tick();
      if (i < 8) begin
        chk("walk_set", 32'(ctrl.flush_set), 32'(i >> 1));
        chk("walk_way", 32'(ctrl.flush_way), 32'(i & 1));
        chk("walk_no_done", 32'(ctrl.flush_done), 0);
      end
    end
    chk("walk_done", 32'(ctrl.flush_done), 1);
    chk("walk_done_ongoing", 32'(ctrl.ongoing_flush), 0);
    chk("walk_done_pos", 32'({ctrl.flush_set, ctrl.flush_way}), 0);
    tick();
    chk("walk_done_once", 32'(ctrl.flush_done), 0);
    chk("walk_idle_ongoing", 32'(ctrl.ongoing_flush), 0);

    // Abort at set 2, same cycle as a step
    ctrl.start_flush = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ctrl.step_flush = 1'b1;
      tick();
    end
    chk("abort_pre_set", 32'(ctrl.flush_set), 2);
    ctrl.abort_flush = 1'b1;
    ctrl.step_flush  = 1'b1;
    tick();
    chk("abort_ongoing", 32'(ctrl.ongoing_flush), 0);
    chk("abort_pos", 32'({ctrl.flush_set, ctrl.flush_way}), 0);
    chk("abort_no_done", 32'(ctrl.flush_done), 0);
    tick();
    chk("abort_no_done2", 32'(ctrl.flush_done), 0);

    // Credits
    for (int i = 1; i <= 4; i++) begin
      ctrl.req_alloc = 1'b1;
      tick();
      chk("cred_alloc_cnt", 32'(ctrl.reqs_cnt), 32'(4 - i));
    end
    chk("cred_none_free", 32'(ctrl.reqs_none_free), 1);
    chk("cred_all_free0", 32'(ctrl.reqs_all_free), 0);
    ctrl.req_alloc = 1'b1;
    tick();
    chk("cred_under_cnt", 32'(ctrl.reqs_cnt), 0);
    chk("cred_under_flag", 32'(ctrl.err_underflow), 1);
    ctrl.req_alloc = 1'b1;
    ctrl.req_free  = 1'b1;
    tick();
    chk("cred_both_cnt", 32'(ctrl.reqs_cnt), 0);
    chk("cred_both_over", 32'(ctrl.err_overflow), 0);
    ctrl.clr_err = 1'b1;
    tick();
    chk("cred_clr_err", 32'({ctrl.err_underflow, ctrl.err_overflow}), 0);
    for (int i = 1; i <= 4; i++) begin
      ctrl.req_free = 1'b1;
      tick();
    end
    chk("cred_full_cnt", 32'(ctrl.reqs_cnt), 4);
    chk("cred_all_free", 32'(ctrl.reqs_all_free), 1);
    ctrl.req_free = 1'b1;
    tick();
    chk("cred_over_cnt", 32'(ctrl.reqs_cnt), 4);
    chk("cred_over_flag", 32'(ctrl.err_overflow), 1);
    ctrl.req_free = 1'b1;
    ctrl.clr_err  = 1'b1;
    tick();
    chk("cred_clr_prio", 32'(ctrl.err_overflow), 0);

    // Stall slots
    ctrl.set_stall = 1'b1; ctrl.set_stall_idx = 2'd3;
    tick();
    chk("stall_valid01", 32'(ctrl.stall_valid), 1);
    chk("stall_fwd", 32'(ctrl.fwd_stall), 1);
    ctrl.set_stall = 1'b1; ctrl.set_stall_idx = 2'd1;
    tick();
    chk("stall_valid11", 32'(ctrl.stall_valid), 3);
    ctrl.set_stall = 1'b1; ctrl.set_stall_idx = 2'd0;
    tick();
    chk("stall_fail_pulse", 32'(ctrl.stall_alloc_fail), 1);
    chk("stall_fail_valid", 32'(ctrl.stall_valid), 3);
    tick();
    chk("stall_fail_gone", 32'(ctrl.stall_alloc_fail), 0);
    chk("stall_no_ended", 32'(ctrl.fwd_stall_ended), 0);
    ctrl.wr_en_put_reqs = 1'b1; ctrl.reqs_i = 2'd1;
    tick();
    chk("stall_ended", 32'(ctrl.fwd_stall_ended), 1);
    chk("stall_eslot1", 32'(ctrl.ended_slot), 1);
    ctrl.wr_en_put_reqs = 1'b1; ctrl.reqs_i = 2'd0;
    ctrl.put_reqs_atomic = 1'b1; ctrl.reqs_atomic_i = 2'd3;
    tick();
    chk("stall_atomic_eslot0", 32'(ctrl.ended_slot), 0);
    ctrl.clr_stall = 1'b1; ctrl.clr_stall_slot = 1'b0;
    ctrl.set_stall = 1'b1; ctrl.set_stall_idx = 2'd2;
    tick();
    chk("stall_realloc_valid", 32'(ctrl.stall_valid), 3);
    chk("stall_realloc_fail", 32'(ctrl.stall_alloc_fail), 0);
    chk("stall_realloc_eslot", 32'(ctrl.ended_slot), 1);
    ctrl.wr_en_put_reqs = 1'b1; ctrl.reqs_i = 2'd3;
    tick();
    chk("stall_oldidx_nomatch", 32'(ctrl.ended_slot), 1);
    ctrl.wr_en_put_reqs = 1'b1; ctrl.reqs_i = 2'd2;
    tick();
    chk("stall_newidx_match", 32'(ctrl.ended_slot), 0);
    ctrl.clr_stall = 1'b1; ctrl.clr_stall_slot = 1'b1;
    tick();
    chk("stall_clr1_valid", 32'(ctrl.stall_valid), 1);
    ctrl.set_stall = 1'b1; ctrl.set_stall_idx = 2'd1;
    ctrl.wr_en_put_reqs = 1'b1; ctrl.reqs_i = 2'd1;
    ctrl.clr_stall = 1'b1; ctrl.clr_stall_slot = 1'b0;
    tick();
    chk("stall_samecyc_valid", 32'(ctrl.stall_valid), 1);
    chk("stall_samecyc_nomatch", 32'(ctrl.fwd_stall_ended), 0);

    // Flags
    ctrl.flag_set = 4'b1011;
    tick();
    chk("flags_set", 32'(ctrl.flags), 32'h0000000b);
    ctrl.flag_set = 4'b0100; ctrl.flag_clr = 4'b0001;
    tick();
    chk("flags_setclr", 32'(ctrl.flags), 32'h0000000e);
    ctrl.flag_set = 4'b1000; ctrl.flag_clr = 4'b1000;
    tick();
    chk("flags_clr_wins", 32'(ctrl.flags), 32'h00000006);
    ctrl.flag_clr = 4'b1111;
    tick();
    chk("flags_clr_all", 32'(ctrl.flags), 0);

    // Asynchronous reset in the middle of a walk
    ctrl.start_flush = 1'b1;
    tick();
    ctrl.step_flush = 1'b1;
    tick();
    ctrl.step_flush = 1'b1;
    ctrl.req_alloc  = 1'b1;
    ctrl.flag_set   = 4'b0101;
    tick();
    chk("mid_set1", 32'(ctrl.flush_set), 1);
    chk("mid_slot", 32'(ctrl.stall_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state("async_rst");
    #10;
    rst = 1'b1;
    tick();
    chk("post_rst_cnt", 32'(ctrl.reqs_cnt), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
